// File: rtl/hier_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | hier_seq_ctrl : job sequencer for the hier DTW core (ref load, sample    |
// |                 window, start/angle_rdy handshake, score report)         |
// | Optional timeout watchdog: define HIER_TIMEOUT_EN                        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hier_seq_ctrl #(
    parameter int COORD_DEPTH = 8,
    parameter int ANGLE_DEPTH = 32,
    parameter int REF_LEN     = 22,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic                   ref_valid,
    input  logic [ANGLE_DEPTH-1:0] ref_data,
    output logic                   ref_ready,
    input  logic                   pt_valid,
    input  logic [COORD_DEPTH-1:0] pt_x,
    input  logic [COORD_DEPTH-1:0] pt_y,
    output logic                   pt_ready,
    input  logic [31:0]            thresh,
    output logic                   core_fill,
    output logic [ANGLE_DEPTH-1:0] core_refer,
    output logic                   core_start,
    output logic [COORD_DEPTH-1:0] core_x0,
    output logic [COORD_DEPTH-1:0] core_y0,
    output logic [COORD_DEPTH-1:0] core_x1,
    output logic [COORD_DEPTH-1:0] core_y1,
    output logic [COORD_DEPTH-1:0] core_x2,
    output logic [COORD_DEPTH-1:0] core_y2,
    input  logic                   core_angle_rdy,
    input  logic [31:0]            core_score,
    input  logic                   core_done,
    output logic                   busy,
    output logic                   result_valid,
    output logic [31:0]            result_score,
    output logic                   result_match,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_REF  = 3'd1,
        S_WAIT_PT   = 3'd2,
        S_SETTLE    = 3'd3,
        S_ISSUE     = 3'd4,
        S_WAIT_ANG  = 3'd5,
        S_WAIT_DONE = 3'd6,
        S_REPORT    = 3'd7
    } state_t;

    localparam int CNT_W = $clog2(REF_LEN + 1);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] REF_LAST    = CNT_W'(REF_LEN - 1);
    localparam logic [CNT_W-1:0] PT_TOTAL    = CNT_W'(REF_LEN);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0]       pt_cnt_q, pt_cnt_d;
    logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic                   fill_q, fill_d;
    logic [ANGLE_DEPTH-1:0] refer_q, refer_d;
    logic [COORD_DEPTH-1:0] wx_q [3];
    logic [COORD_DEPTH-1:0] wy_q [3];
    logic [COORD_DEPTH-1:0] wx_d [3];
    logic [COORD_DEPTH-1:0] wy_d [3];
    logic [31:0]            score_q, score_d;
    logic                   match_q, match_d;
    logic                   w_timed_out;
    logic                   w_match_now;

`ifdef HIER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    assign w_timed_out = err_q;
    assign err         = err_q;
`else
    assign w_timed_out = 1'b0;
    assign err         = 1'b0;

    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // A timed-out job reports a forced miss regardless of thresh.
    assign w_match_now = !w_timed_out && (score_q <= thresh);

    always_comb begin
        state_d      = state_q;
        ref_cnt_d    = ref_cnt_q;
        pt_cnt_d     = pt_cnt_q;
        settle_cnt_d = settle_cnt_q;
        fill_d       = 1'b0;
        refer_d      = refer_q;
        wx_d         = wx_q;
        wy_d         = wy_q;
        score_d      = score_q;
        match_d      = match_q;
`ifdef HIER_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d   = S_LOAD_REF;
                    ref_cnt_d = '0;
`ifdef HIER_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            S_LOAD_REF: begin
                if (ref_valid) begin
                    fill_d  = 1'b1;
                    refer_d = ref_data;
                    if (ref_cnt_q == REF_LAST) begin
                        state_d   = S_WAIT_PT;
                        ref_cnt_d = '0;
                        pt_cnt_d  = '0;
                    end else begin
                        ref_cnt_d = ref_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_PT: begin
                if (pt_valid) begin
                    wx_d[2]      = wx_q[1];
                    wy_d[2]      = wy_q[1];
                    wx_d[1]      = wx_q[0];
                    wy_d[1]      = wy_q[0];
                    wx_d[0]      = pt_x;
                    wy_d[0]      = pt_y;
                    settle_cnt_d = '0;
                    state_d      = (SETTLE_CYC > 0) ? S_SETTLE : S_ISSUE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_ISSUE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_ISSUE: begin
                pt_cnt_d = pt_cnt_q + 1'b1;
                state_d  = S_WAIT_ANG;
            end
            S_WAIT_ANG: begin
                if (core_angle_rdy) begin
                    state_d = (pt_cnt_q == PT_TOTAL) ? S_WAIT_DONE : S_WAIT_PT;
                end
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    score_d = core_score;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                match_d = w_match_now;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef HIER_TIMEOUT_EN
        // Watchdog only runs while stalled on the core's handshakes.
        if ((state_q == S_WAIT_ANG && !core_angle_rdy) ||
            (state_q == S_WAIT_DONE && !core_done)) begin
            if (wait_cnt_q == WAIT_LAST) begin
                err_d      = 1'b1;
                score_d    = 32'hFFFF_FFFF;
                state_d    = S_REPORT;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end else begin
            wait_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ref_cnt_q    <= '0;
            pt_cnt_q     <= '0;
            settle_cnt_q <= '0;
            fill_q       <= 1'b0;
            refer_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                wx_q[i] <= '0;
                wy_q[i] <= '0;
            end
            score_q      <= '0;
            match_q      <= 1'b0;
`ifdef HIER_TIMEOUT_EN
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ref_cnt_q    <= ref_cnt_d;
            pt_cnt_q     <= pt_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            fill_q       <= fill_d;
            refer_q      <= refer_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            score_q      <= score_d;
            match_q      <= match_d;
`ifdef HIER_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign ref_ready    = (state_q == S_LOAD_REF);
    assign pt_ready     = (state_q == S_WAIT_PT);
    assign core_start   = (state_q == S_ISSUE);
    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_REPORT);
    assign result_score = score_q;
    assign result_match = (state_q == S_REPORT) ? w_match_now : match_q;
    assign core_fill    = fill_q;
    assign core_refer   = refer_q;
    assign core_x0      = wx_q[0];
    assign core_y0      = wy_q[0];
    assign core_x1      = wx_q[1];
    assign core_y1      = wy_q[1];
    assign core_x2      = wx_q[2];
    assign core_y2      = wy_q[2];

endmodule

`default_nettype wire

// File: tb/tb_hier_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_hier_seq_ctrl : directed bench for hier_seq_ctrl with result and      |
// |                    reference-word scoreboards                            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hier_seq_ctrl;

    localparam int CD = 8;
    localparam int AD = 32;
    localparam int RL = 22;
    localparam int SC = 2;
    localparam int TO = 16;
`ifdef HIER_TIMEOUT_EN
    localparam int STALL = 10;
`else
    localparam int STALL = 50;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go, ref_valid, pt_valid;
    logic [AD-1:0] ref_data;
    logic [CD-1:0] pt_x, pt_y;
    logic [31:0]   thresh, core_score;
    logic          core_angle_rdy, core_done;
    logic          ref_ready, pt_ready, core_fill, core_start, busy;
    logic          result_valid, result_match, err;
    logic [AD-1:0] core_refer;
    logic [CD-1:0] core_x0, core_y0, core_x1, core_y1, core_x2, core_y2;
    logic [31:0]   result_score;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_ref_q [$];
    logic [31:0] exp_score_q [$];
    logic        exp_match_q [$];
    logic [CD-1:0] mx [3];
    logic [CD-1:0] my [3];

    always #5 clk = ~clk;

    hier_seq_ctrl #(
        .COORD_DEPTH(CD), .ANGLE_DEPTH(AD), .REF_LEN(RL),
        .SETTLE_CYC(SC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .ref_valid(ref_valid), .ref_data(ref_data), .ref_ready(ref_ready),
        .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_ready(pt_ready),
        .thresh(thresh),
        .core_fill(core_fill), .core_refer(core_refer), .core_start(core_start),
        .core_x0(core_x0), .core_y0(core_y0), .core_x1(core_x1),
        .core_y1(core_y1), .core_x2(core_x2), .core_y2(core_y2),
        .core_angle_rdy(core_angle_rdy), .core_score(core_score), .core_done(core_done),
        .busy(busy), .result_valid(result_valid), .result_score(result_score),
        .result_match(result_match), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_window();
        chk("win_x0", core_x0, mx[0]);
        chk("win_y0", core_y0, my[0]);
        chk("win_x1", core_x1, mx[1]);
        chk("win_y1", core_y1, my[1]);
        chk("win_x2", core_x2, mx[2]);
        chk("win_y2", core_y2, my[2]);
    endtask

    task automatic load_refs();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("load_busy", busy, 1'b1);
        chk("load_ref_ready", ref_ready, 1'b1);
        for (int i = 0; i < RL; i++) begin
            ref_valid = 1'b1;
            ref_data  = 32'(45 + 10 * i);
            exp_ref_q.push_back(ref_data);
            tick();
            chk("fill_pulse", core_fill, 1'b1);
            chk("refer_word", core_refer, exp_ref_q.pop_front());
        end
        ref_valid = 1'b0;
        chk("ref_ready_drop", ref_ready, 1'b0);
        chk("pt_ready_after_load", pt_ready, 1'b1);
        tick();
        chk("fill_low", core_fill, 1'b0);
        chk("refer_hold", core_refer, 32'd255);
    endtask

    task automatic send_pt(input logic [CD-1:0] x, input logic [CD-1:0] y, input int stall);
        pt_valid = 1'b1;
        pt_x     = x;
        pt_y     = y;
        chk("pt_ready", pt_ready, 1'b1);
        tick();
        pt_valid = 1'b0;
        mx[2] = mx[1]; my[2] = my[1];
        mx[1] = mx[0]; my[1] = my[0];
        mx[0] = x;     my[0] = y;
        chk_window();
        chk("settle_no_start0", core_start, 1'b0);
        tick();
        chk("settle_no_start1", core_start, 1'b0);
        tick();
        chk("start_pulse", core_start, 1'b1);
        tick();
        chk("start_one_cycle", core_start, 1'b0);
        for (int i = 0; i < stall; i++) begin
            chk("stall_pt_ready", pt_ready, 1'b0);
            chk("stall_no_start", core_start, 1'b0);
            tick();
        end
        core_angle_rdy = 1'b1;
        tick();
        core_angle_rdy = 1'b0;
    endtask

    task automatic run_rest_samples();
        for (int i = 5; i < RL; i++) begin
            if (i == 10) begin
                // stray done outside WAIT_DONE must be ignored
                core_score = 32'd999;
                core_done  = 1'b1;
                tick();
                core_done  = 1'b0;
                chk("stray_done_no_result", result_valid, 1'b0);
            end
            send_pt(CD'(i), CD'(-i), 0);
            if (i < RL - 1) chk("pt_ready_again", pt_ready, 1'b1);
        end
        chk("wait_done_busy", busy, 1'b1);
        chk("wait_done_pt_ready", pt_ready, 1'b0);
        chk("wait_done_no_result", result_valid, 1'b0);
    endtask

    task automatic finish_job(input logic [31:0] score, input logic [31:0] th);
        int n;
        thresh     = th;
        core_score = score;
        exp_score_q.push_back(score);
        exp_match_q.push_back(score <= th);
        core_done  = 1'b1;
        tick();
        core_done  = 1'b0;
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        chk("result_arrived", (n < 20), 1'b1);
        chk("result_score", result_score, exp_score_q.pop_front());
        chk("result_match", result_match, exp_match_q.pop_front());
        tick();
        chk("result_one_cycle", result_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("score_hold", result_score, score);
        chk("match_hold", result_match, (score <= th));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; go = 1'b0; ref_valid = 1'b0; pt_valid = 1'b0;
        ref_data = '0; pt_x = '0; pt_y = '0; thresh = '0;
        core_score = '0; core_angle_rdy = 1'b0; core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mx[i] = '0;
            my[i] = '0;
        end
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", core_start, 1'b0);
        chk("rst_fill", core_fill, 1'b0);
        chk("rst_refer", core_refer, 32'd0);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_result_score", result_score, 32'd0);
        chk("rst_err", err, 1'b0);
        chk_window();
        rst_n = 1'b1;
        tick();

        ref_valid = 1'b1;
        ref_data  = 32'd7;
        tick();
        ref_valid = 1'b0;
        chk("idle_no_accept", core_fill, 1'b0);

        // job 1: full run, exact-threshold match
        load_refs();
        send_pt(8'd70, 8'd90, 0);
        send_pt(8'd60, 8'd100, 0);
        send_pt(8'd50, 8'd110, 0);
        chk("t3_x0", core_x0, 8'd50);
        chk("t3_y0", core_y0, 8'd110);
        chk("t3_x1", core_x1, 8'd60);
        chk("t3_y1", core_y1, 8'd100);
        chk("t3_x2", core_x2, 8'd70);
        chk("t3_y2", core_y2, 8'd90);
        send_pt(8'hB0, 8'h88, 0);
        chk("neg_x0", core_x0, 8'hB0);
        chk("neg_y0", core_y0, 8'h88);
        send_pt(8'd5, 8'hFB, STALL);
        chk("stall_release_pt_ready", pt_ready, 1'b1);
        run_rest_samples();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_busy_ignored", ref_ready, 1'b0);
        chk("go_busy_still_busy", busy, 1'b1);
        finish_job(32'd1234, 32'd1234);

        // job 2: reset while waiting on angle_rdy
        load_refs();
        pt_valid = 1'b1;
        pt_x = 8'd1;
        pt_y = 8'd2;
        tick();
        pt_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("wait_ang_busy", busy, 1'b1);
        chk("wait_ang_pt_ready", pt_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            mx[i] = '0;
            my[i] = '0;
        end
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_start", core_start, 1'b0);
        chk("mid_rst_score", result_score, 32'd0);
        chk("mid_rst_match", result_match, 1'b0);
        chk_window();
        tick();
        rst_n = 1'b1;
        tick();

        // job 3: clean run after reset, threshold just below score
        load_refs();
        send_pt(8'd70, 8'd90, 0);
        send_pt(8'd60, 8'd100, 0);
        send_pt(8'd50, 8'd110, 0);
        send_pt(8'hB0, 8'h88, 0);
        send_pt(8'd5, 8'hFB, 0);
        run_rest_samples();
        finish_job(32'd1234, 32'd1233);

`ifdef HIER_TIMEOUT_EN
        begin
            int n;
            load_refs();
            pt_valid = 1'b1;
            pt_x = 8'd3;
            pt_y = 8'd4;
            tick();
            pt_valid = 1'b0;
            tick();
            tick();
            tick();
            n = 0;
            while (!result_valid && n < 40) begin
                tick();
                n++;
            end
            chk("to_cycles", 32'(n), 32'(TO));
            chk("to_err", err, 1'b1);
            chk("to_score", result_score, 32'hFFFF_FFFF);
            chk("to_match", result_match, 1'b0);
            tick();
            chk("to_idle", busy, 1'b0);
            chk("to_err_hold", err, 1'b1);
            go = 1'b1;
            tick();
            go = 1'b0;
            chk("to_err_clear", err, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
